// File: rtl/op2_imm_encoder.sv
// Iterative ARM operand-2 immediate encoder: finds {rot4, imm8} with value == imm8 ROR (2*rot4),
// testing one rotation per cycle. Optional second pass over ~value under OP2_INVERT_EN.
module op2_imm_encoder #(
   parameter int ROT_STEPS = 16,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] value,
   input  logic              carry_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              found,
   output logic [7:0]        imm8,
   output logic [3:0]        rot4,
   output logic              carry_out,
   output logic              inverted,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // out_valid and all result fields are held stable until that transfer.

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] LAST_K = 4'(ROT_STEPS - 1);

   state_t            state_q;
   logic [DATA_W-1:0] val_q;
   logic              cin_q;
   logic [3:0]        k_q;
   logic              out_valid_q;
   logic              found_q;
   logic [7:0]        imm8_q;
   logic [3:0]        rot4_q;
   logic              carry_q;

   logic [DATA_W-1:0]   cand_d;
   logic [2*DATA_W-1:0] dbl_d;
   logic [DATA_W-1:0]   rol_d;
   logic [5:0]          amt_d;
   logic                hit_d;

`ifdef OP2_INVERT_EN
   logic pass_q;
   logic inv_q;
   assign cand_d   = pass_q ? ~val_q : val_q;
   assign inverted = inv_q;
`else
   assign cand_d   = val_q;
   assign inverted = 1'b0;
`endif

   // Rotate-left by 2*k via a doubled word; rotate by 0 leaves the upper half untouched.
   assign amt_d = {1'b0, k_q, 1'b0};
   assign dbl_d = {cand_d, cand_d} << amt_d;
   assign rol_d = dbl_d[2*DATA_W-1:DATA_W];
   assign hit_d = (rol_d[DATA_W-1:8] == '0);

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign found     = found_q;
   assign imm8      = imm8_q;
   assign rot4      = rot4_q;
   assign carry_out = carry_q;
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         val_q       <= '0;
         cin_q       <= 1'b0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         found_q     <= 1'b0;
         imm8_q      <= '0;
         rot4_q      <= '0;
         carry_q     <= 1'b0;
`ifdef OP2_INVERT_EN
         pass_q      <= 1'b0;
         inv_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  val_q   <= value;
                  cin_q   <= carry_in;
                  k_q     <= '0;
`ifdef OP2_INVERT_EN
                  pass_q  <= 1'b0;
`endif
                  state_q <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               if (hit_d) begin
                  found_q     <= 1'b1;
                  imm8_q      <= rol_d[7:0];
                  rot4_q      <= k_q;
                  // A non-zero rotate puts the top bit of the encoded word on the carry.
                  carry_q     <= (k_q == 4'd0) ? cin_q : cand_d[DATA_W-1];
`ifdef OP2_INVERT_EN
                  inv_q       <= pass_q;
`endif
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else if (k_q == LAST_K) begin
`ifdef OP2_INVERT_EN
                  if (!pass_q) begin
                     pass_q <= 1'b1;
                     k_q    <= '0;
                  end else begin
                     found_q     <= 1'b0;
                     imm8_q      <= '0;
                     rot4_q      <= '0;
                     carry_q     <= cin_q;
                     inv_q       <= 1'b0;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end
`else
                  found_q     <= 1'b0;
                  imm8_q      <= '0;
                  rot4_q      <= '0;
                  carry_q     <= cin_q;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
`endif
               end else begin
                  k_q <= k_q + 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_op2_imm_encoder.sv
// Bench for op2_imm_encoder: random and directed constants, reference encoder model,
// expected-result queue drained by a monitor that also applies random backpressure.
module tb_op2_imm_encoder;

   localparam int EW = 21;  // {lat[5:0], found, imm8[7:0], rot4[3:0], carry, inv}

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] value;
   logic        carry_in;
   logic        out_valid;
   logic        out_ready;
   logic        found;
   logic [7:0]  imm8;
   logic [3:0]  rot4;
   logic        carry_out;
   logic        inverted;
   logic [1:0]  dbg_state;

   logic [EW-1:0] exp_q[$];
   int            e0_q[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            hold = 0;

   op2_imm_encoder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .value     (value),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .found     (found),
      .imm8      (imm8),
      .rot4      (rot4),
      .carry_out (carry_out),
      .inverted  (inverted),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // reference model
   function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
      logic [31:0] r;
      r = x;
      for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
      return r;
   endfunction

   function automatic logic [EW-1:0] model(input logic [31:0] v, input logic c);
      int          npass;
      logic [31:0] tv;
      logic [31:0] cand;
      logic        cy;
      logic [5:0]  lat;
`ifdef OP2_INVERT_EN
      npass = 2;
`else
      npass = 1;
`endif
      for (int p = 0; p < npass; p++) begin
         tv = (p == 1) ? ~v : v;
         for (int r = 0; r < 16; r++) begin
            cand = ror32(tv, (32 - 2 * r) % 32);
            if (cand < 32'd256 && ror32(cand, 2 * r) == tv) begin
               cy  = (r == 0) ? c : tv[31];
               lat = 6'(p * 16 + r + 1);
               return {lat, 1'b1, cand[7:0], 4'(r), cy, (p == 1)};
            end
         end
      end
      lat = 6'(16 * npass);
      return {lat, 1'b0, 8'h00, 4'h0, c, 1'b0};
   endfunction

   // driver
   task automatic issue(input logic [31:0] v, input logic c);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: in_ready stuck at 0 expected 1 (cycle %0d)", cyc);
         return;
      end
      value    = v;
      carry_in = c;
      in_valid = 1'b1;
      exp_q.push_back(model(v, c));
      e0_q.push_back(cyc + 1);
      @(negedge clk);
      in_valid = 1'b0;
      value    = $urandom;
      carry_in = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
      end
   endtask

   // monitor / scoreboard
   initial begin
      logic [EW-1:0] e;
      logic [14:0]   snap;
      logic          seen;
      logic          retired;
      seen    = 1'b0;
      retired = 1'b0;
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            seen      = 1'b0;
            retired   = 1'b0;
            out_ready = 1'b0;
            continue;
         end
         if (retired) begin
            check("retire_valid", 32'(out_valid), 32'd0);
            check("ready_after_retire", 32'(in_ready), 32'd1);
            retired = 1'b0;
         end
         if (out_valid) begin
            if (!seen) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_valid: out_valid 1 expected 0 (cycle %0d)", cyc);
               end else begin
                  e = exp_q[0];
                  check("result", 32'({found, imm8, rot4, carry_out, inverted}), 32'(e[14:0]));
                  check("latency", 32'(cyc - e0_q[0]), 32'(e[20:15]));
               end
               snap = {found, imm8, rot4, carry_out, inverted};
               seen = 1'b1;
            end else begin
               check("stable", 32'({found, imm8, rot4, carry_out, inverted}), 32'(snap));
            end
            check("busy_ready", 32'(in_ready), 32'd0);
            if (hold > 0) begin
               out_ready = 1'b0;
               hold--;
            end else begin
               out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_ready) begin
               if (exp_q.size() != 0) begin
                  void'(exp_q.pop_front());
                  void'(e0_q.pop_front());
               end
               seen    = 1'b0;
               retired = 1'b1;
            end
         end else begin
            out_ready = 1'b0;
         end
      end
   end

   // stimulus
   initial begin
      logic [31:0] v;
      int          r;
      in_valid = 1'b0;
      value    = '0;
      carry_in = 1'b0;
      reset_n  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_fields", 32'({found, imm8, rot4, carry_out, inverted}), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      reset_n = 1'b1;

      issue(32'h0000_00FF, 1'b0);
      issue(32'hF000_000F, 1'b0);
      issue(32'h0000_03FC, 1'b1);
      issue(32'h0000_0101, 1'b1);
      issue(32'hFFFF_FF00, 1'b1);
      issue(32'h0000_0000, 1'b1);
      wait_drain(400);

      // held result with in_valid pulses that must be ignored
      hold = 5;
      issue(32'h0000_00FF, 1'b1);
      @(negedge clk);
      in_valid = 1'b1;
      value    = 32'h1234_5678;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      wait_drain(100);

      // reset while k=7 of a non-encodable constant
      issue(32'h0000_0101, 1'b1);
      while (cyc < e0_q[0] + 7) @(negedge clk);
      #2 reset_n = 1'b0;
      exp_q.delete();
      e0_q.delete();
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_fields", 32'({found, imm8, rot4, carry_out, inverted}), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      issue(32'h0000_0000, 1'b0);
      wait_drain(100);

      // randomized mix: encodable, inverted-encodable, arbitrary
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 15);
         v = ror32(32'($urandom_range(0, 255)), 2 * r);
         case ($urandom_range(0, 2))
            0: issue(v, 1'($urandom_range(0, 1)));
            1: issue(~v, 1'($urandom_range(0, 1)));
            default: issue($urandom, 1'($urandom_range(0, 1)));
         endcase
      end
      wait_drain(2000);
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
